demux_8way_1bit_chip: RTL and testbench
=======================================

// Module: demux_8way_1bit_chip
// PURPOSE
//   1-bit, 8-way demultiplexer with registered outputs.
//   Routes the single data input to the one output selected by the 3-bit select; the other seven outputs are 0.
//   Leaf combinational-plus-register building block of the chips library.
//   Feeds wider demux chips and address-decode logic in the datapath.
// PARAMETERS
//   none: width (1 bit) and way count (8) are fixed by the chip definition.
// PORTS
//   clk    input   1  system clock; all state updates on the rising edge
//   reset  input   1  synchronous, active-high reset
//   o1     output  1  way 0 output (sel = 3'b000)
//   o2     output  1  way 1 output (sel = 3'b001)
//   o3     output  1  way 2 output (sel = 3'b010)
//   o4     output  1  way 3 output (sel = 3'b011)
//   o5     output  1  way 4 output (sel = 3'b100)
//   o6     output  1  way 5 output (sel = 3'b101)
//   o7     output  1  way 6 output (sel = 3'b110)
//   o8     output  1  way 7 output (sel = 3'b111)
//   in     input   1  data bit to route
//   sel    input   3  way select, binary; sel = k selects o(k+1)
//   Positional port order: clk, reset, o1..o8, in, sel.
// BEHAVIOUR
//   - One clock, single always block on posedge clk; no combinational input-to-output path.
//   - Reset: when reset = 1 at a rising edge, o1..o8 <= 0 on that edge.
//     - Reset has priority over in/sel.
//     - Reset held for N cycles keeps all outputs 0 for N cycles.
//   - Normal operation: at each rising edge with reset = 0:
//     - o(sel+1) <= in;
//     - every other output <= 0.
//   - Latency: exactly 1 cycle from in/sel sampled at edge t to outputs valid after edge t.
//   - Stream rate: one new in/sel pair every cycle, no stall, no handshake.
//   - Exactly one output may be 1 at any time (one-hot or all-zero).
//     - in = 0 gives all outputs 0 regardless of sel.
//   - sel changing every cycle: outputs follow cycle by cycle.
//     - A previously selected output clears to 0 on the next edge.
//   - Boundary ways: sel = 3'b000 drives o1 and sel = 3'b111 drives o8; no wrap, all 8 codes valid.
//   - Reset deasserted mid-stream: the first non-reset edge registers the current in/sel normally.
//   - Power-up before the first reset: outputs undefined; the system must apply reset.
//   - X/Z on sel: no defined behaviour required; the bench must not drive it.
// STRUCTURE
//   - Shared package chips_pkg holds:
//     - localparam DEMUX8_WAYS = 8;
//     - localparam DEMUX8_SEL_W = 3.
//   - Datapath: binary tree of 2-way demuxes.
//     - sel[2] splits ways 0-3 / 4-7;
//     - sel[1] splits pairs;
//     - sel[0] picks the final way;
//     - 7 instances total.
//   - The tree result goes to an 8-bit output register with synchronous reset.
//     - Register bits map one-to-one onto o1..o8.
//   - One sub-module: demux_2way_1bit (in, sel -> a = in & ~sel, b = in & sel), purely combinational.
// TESTING
//   - Reset: reset = 1 for 2 cycles with in = 1, sel = 3'b101 -> o1..o8 = 0 after each edge.
//   - Way sweep: reset = 0, in = 1, sel = 000..111 one per cycle.
//     - Each edge sets only o(sel+1) = 1: o1 after sel 000, ..., o8 after sel 111.
//     - Previously high output returns to 0 on the next edge.
//   - Zero data: in = 0, each of the 8 sel codes -> all outputs 0 every cycle.
//   - Latency check: change sel 3'b010 -> 3'b110 between edges -> o3 stays 1 until the next edge, then o7 = 1 and o3 = 0.
//   - Mid-stream reset: in = 1, sel = 3'b111, o8 = 1; assert reset for one edge -> o8 = 0.
//     - Deassert -> o8 = 1 after the following edge.
//   - Random stream (>= 200 cycles): scoreboard 1-cycle-delayed one-hot model; assert onehot0({o8..o1}) every cycle.

Source files
------------

// File: rtl/chips_pkg.sv
// rtl/chips_pkg.sv - shared constants for the chips library
package chips_pkg;
  localparam int DEMUX8_WAYS  = 8;
  localparam int DEMUX8_SEL_W = 3;
endpackage

// File: rtl/demux_2way_1bit.sv
// rtl/demux_2way_1bit.sv - combinational 1-bit 2-way demux leaf
module demux_2way_1bit (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = in & ~sel;
  assign b = in & sel;
endmodule

// File: rtl/demux_8way_1bit_chip.sv
// rtl/demux_8way_1bit_chip.sv - 1-bit 8-way demux, tree of 2-way demuxes into a registered output
module demux_8way_1bit_chip
  import chips_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  output logic                    o1,
  output logic                    o2,
  output logic                    o3,
  output logic                    o4,
  output logic                    o5,
  output logic                    o6,
  output logic                    o7,
  output logic                    o8,
  input  logic                    in,
  input  logic [DEMUX8_SEL_W-1:0] sel
);
  logic [1:0]             l1;
  logic [3:0]             l2;
  logic [DEMUX8_WAYS-1:0] way;
  logic [DEMUX8_WAYS-1:0] out_d;
  logic [DEMUX8_WAYS-1:0] out_q;

  // sel[2] halves, sel[1] picks a pair, sel[0] picks the way inside the pair
  demux_2way_1bit u_l1 (.in(in), .sel(sel[2]), .a(l1[0]), .b(l1[1]));

  for (genvar i = 0; i < 2; i++) begin : g_l2
    demux_2way_1bit u_d (.in(l1[i]), .sel(sel[1]), .a(l2[2*i]), .b(l2[2*i+1]));
  end

  for (genvar i = 0; i < 4; i++) begin : g_l3
    demux_2way_1bit u_d (.in(l2[i]), .sel(sel[0]), .a(way[2*i]), .b(way[2*i+1]));
  end

  always_comb begin
    out_d = way;
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign {o8, o7, o6, o5, o4, o3, o2, o1} = out_q;
endmodule

// File: tb/tb_demux_8way_1bit_chip.sv
// tb/tb_demux_8way_1bit_chip.sv - self-checking bench for demux_8way_1bit_chip
module tb_demux_8way_1bit_chip;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in = 1'b0;
  logic [2:0] sel = 3'd0;
  logic       o1, o2, o3, o4, o5, o6, o7, o8;
  logic [7:0] outs;
  logic [7:0] exp_v = 8'd0;
  logic       model_ok = 1'b0;
  int         total = 0;
  int         bad = 0;

  localparam logic [7:0] SWEEP_EXP [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                           8'h10, 8'h20, 8'h40, 8'h80};

  demux_8way_1bit_chip dut (
    .clk(clk), .reset(reset),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8),
    .in(in), .sel(sel)
  );

  always #5 clk = ~clk;

  assign outs = {o8, o7, o6, o5, o4, o3, o2, o1};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the registered word is in placed at bit sel, or nothing under reset
  always @(posedge clk) begin
    exp_v    <= reset ? 8'd0 : (in ? (8'd1 << sel) : 8'd0);
    model_ok <= model_ok | reset;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model", outs, exp_v);
      chk("onehot0", {7'd0, $onehot0(outs)}, 8'd1);
    end
  end

  task automatic drive(input logic r, input logic i, input logic [2:0] s);
    reset = r;
    in    = i;
    sel   = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tick();
    drive(1'b1, 1'b1, 3'b101);
    tick(); chk("reset_edge1", outs, 8'h00);
    tick(); chk("reset_edge2", outs, 8'h00);

    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 3'(k));
      tick(); chk("sweep", outs, SWEEP_EXP[k]);
    end

    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 3'(k));
      tick(); chk("zero_data", outs, 8'h00);
    end

    drive(1'b0, 1'b1, 3'b010);
    tick(); chk("lat_o3", outs, 8'h04);
    drive(1'b0, 1'b1, 3'b110);
    #1;     chk("lat_hold", outs, 8'h04);
    tick(); chk("lat_o7", outs, 8'h40);

    drive(1'b0, 1'b1, 3'b111);
    tick(); chk("mid_pre", outs, 8'h80);
    drive(1'b1, 1'b1, 3'b111);
    tick(); chk("mid_rst", outs, 8'h00);
    drive(1'b0, 1'b1, 3'b111);
    tick(); chk("mid_post", outs, 8'h80);

    for (int n = 0; n < 300; n++) begin
      drive(($urandom % 12) == 0, 1'($urandom), 3'($urandom_range(7, 0)));
      tick();
    end
    drive(1'b0, 1'b0, 3'd0);
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
